mem_port_arbiter: RTL and testbench

Shares one single-ported memory between the pipeline's instruction-fetch port and data-memory port. The block arbitrates each access, holds the granted request on the memory bus until the memory acknowledges, and returns read data with a one-cycle done pulse. While a requester is waiting, the block drives that requester's stall output so the hazard logic can freeze the pipeline. It sits between the fetch/memory stages and the external memory model.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch (if_*) and data (dm_*) ports.
// Optional fetch-starvation guard compiled in with `define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_done,
    output logic                  if_stall,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_done,
    output logic                  dm_stall,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_dm_q, owner_dm_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
    logic                    if_done_q, if_done_d;
    logic                    dm_done_q, dm_done_d;

    logic                    any_req;
    logic                    arbitrate;
    logic                    grant_if;
    logic                    starve_hit;

    assign any_req   = if_req | dm_req;
    assign arbitrate = (state_q == IDLE) && any_req;
    // Data port wins ties unless the starvation guard forces a fetch grant.
    assign grant_if  = if_req & (~dm_req | starve_hit);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1) < 1 ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arbitrate) begin
            if (grant_if || !if_req) begin
                starve_cnt_d = '0;
            end else if (!starve_hit) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // State and datapath registers; reset clears everything, abandoning any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_dm_d  = owner_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_dm_d = ~grant_if;
                    mem_req_d  = 1'b1;
                    if (grant_if) begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                    end else begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_dm_q) begin
                        dm_done_d = 1'b1;
                        if (!mem_we_q) dm_rdata_d = mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %h want 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we got %h want 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        vectors++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, dm_rdata); end
        vectors++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b/%b want 0/0", if_done, dm_done); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_no_req got %h want 0", mem_req); end
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        vectors++; if (if_stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_idle got %b want 1", if_stall); end
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("FAIL fetch_busy_req_we got %b%b want 10", mem_req, mem_we); end
        vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("FAIL fetch_addr got %h want 00000040", mem_addr); end
        vectors++; if (if_stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_busy1 got %b want 1", if_stall); end
        tick();
        vectors++; if (mem_req !== 1'b1 || if_done !== 1'b0) begin miscompares++; $display("FAIL fetch_busy2 got req=%b done=%b want 1/0", mem_req, if_done); end
        mem_ack = 1'b1; mem_rdata = 32'h2002000A;
        tick();
        vectors++; if (if_done !== 1'b1) begin miscompares++; $display("FAIL fetch_done got %b want 1", if_done); end
        vectors++; if (if_rdata !== 32'h2002000A) begin miscompares++; $display("FAIL fetch_rdata got %h want 2002000a", if_rdata); end
        vectors++; if (if_stall !== 1'b0) begin miscompares++; $display("FAIL fetch_stall_done got %b want 0", if_stall); end
        vectors++; if (mem_req !== 1'b0 || dm_done !== 1'b0) begin miscompares++; $display("FAIL fetch_resp_req_dmdone got %b/%b want 0/0", mem_req, dm_done); end
        if_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        vectors++; if (if_done !== 1'b0) begin miscompares++; $display("FAIL fetch_done_one_cycle got %b want 0", if_done); end
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_wdata = 32'h99;
        tick();
        vectors++; if (mem_addr !== 32'h80 || mem_we !== 1'b0) begin miscompares++; $display("FAIL sim_dm_first got addr=%h we=%b want 80/0", mem_addr, mem_we); end
        vectors++; if (if_stall !== 1'b1 || dm_stall !== 1'b1) begin miscompares++; $display("FAIL sim_stalls got %b%b want 11", if_stall, dm_stall); end
        mem_ack = 1'b1; mem_rdata = 32'h5;
        tick();
        vectors++; if (dm_done !== 1'b1 || if_done !== 1'b0) begin miscompares++; $display("FAIL sim_dm_done got dm=%b if=%b want 1/0", dm_done, if_done); end
        vectors++; if (dm_rdata !== 32'h5) begin miscompares++; $display("FAIL sim_dm_rdata got %h want 5", dm_rdata); end
        vectors++; if (dm_stall !== 1'b0 || if_stall !== 1'b1) begin miscompares++; $display("FAIL sim_resp_stalls got dm=%b if=%b want 0/1", dm_stall, if_stall); end
        dm_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL sim_idle_gap got %b want 0", mem_req); end
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0) begin miscompares++; $display("FAIL sim_if_second got req=%b addr=%h we=%b want 1/44/0", mem_req, mem_addr, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        tick();
        vectors++; if (if_done !== 1'b1 || if_rdata !== 32'h1234) begin miscompares++; $display("FAIL sim_if_done got done=%b rdata=%h want 1/1234", if_done, if_rdata); end
        vectors++; if (dm_rdata !== 32'h5) begin miscompares++; $display("FAIL sim_dm_rdata_hold got %h want 5", dm_rdata); end
        if_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
    endtask

    task automatic test_data_write();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h54; dm_wdata = 32'h7;
        tick();
        vectors++; if (mem_we !== 1'b1 || mem_wdata !== 32'h7 || mem_addr !== 32'h54) begin miscompares++; $display("FAIL wr_busy got we=%b wdata=%h addr=%h want 1/7/54", mem_we, mem_wdata, mem_addr); end
        dm_wdata = 32'hFF; dm_addr = 32'hFC;
        tick();
        vectors++; if (mem_we !== 1'b1 || mem_wdata !== 32'h7 || mem_addr !== 32'h54) begin miscompares++; $display("FAIL wr_hold got we=%b wdata=%h addr=%h want 1/7/54", mem_we, mem_wdata, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        tick();
        vectors++; if (dm_done !== 1'b1) begin miscompares++; $display("FAIL wr_done got %b want 1", dm_done); end
        vectors++; if (dm_rdata !== 32'h5) begin miscompares++; $display("FAIL wr_rdata_unchanged got %h want 5", dm_rdata); end
        vectors++; if (mem_we !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL wr_resp_clear got we=%b req=%b want 0/0", mem_we, mem_req); end
        dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        if_req = 1'b1; if_addr = 32'h60;
        tick();
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_mid_busy got %b want 1", mem_req); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mid_async_drop got %b want 0", mem_req); end
        vectors++; if (dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mid_rdata got %h/%h want 0/0", if_rdata, dm_rdata); end
        mem_ack = 1'b1;
        @(negedge clk);
        vectors++; if (if_done !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_done got done=%b req=%b want 0/0", if_done, mem_req); end
        mem_ack = 1'b0;
        reset = 1'b1;
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h60) begin miscompares++; $display("FAIL rst_mid_rearb got req=%b addr=%h want 1/60", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hABCD;
        tick();
        vectors++; if (if_done !== 1'b1 || if_rdata !== 32'hABCD) begin miscompares++; $display("FAIL rst_mid_complete got done=%b rdata=%h want 1/abcd", if_done, if_rdata); end
        if_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
    endtask

    task automatic test_stray_ack();
        mem_ack = 1'b1; mem_rdata = 32'hBAD;
        tick();
        vectors++; if (mem_req !== 1'b0 || if_done !== 1'b0 || dm_done !== 1'b0) begin miscompares++; $display("FAIL stray_idle got req=%b done=%b%b want 0/00", mem_req, if_done, dm_done); end
        vectors++; if (if_rdata !== 32'hABCD || dm_rdata !== 32'h0) begin miscompares++; $display("FAIL stray_idle_rdata got %h/%h want abcd/0", if_rdata, dm_rdata); end
        mem_ack = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h88;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h11;
        tick();
        vectors++; if (dm_done !== 1'b1 || dm_rdata !== 32'h11) begin miscompares++; $display("FAIL stray_pre_done got done=%b rdata=%h want 1/11", dm_done, dm_rdata); end
        dm_req = 1'b0; mem_rdata = 32'h22;
        tick();
        vectors++; if (dm_done !== 1'b0 || if_done !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL stray_resp got done=%b%b req=%b want 00/0", if_done, dm_done, mem_req); end
        vectors++; if (dm_rdata !== 32'h11) begin miscompares++; $display("FAIL stray_resp_rdata got %h want 11", dm_rdata); end
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
    endtask

    task automatic test_starvation();
        bit exp_if [6];
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        tick();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (mem_addr !== (exp_if[i] ? 32'h200 : 32'h100)) begin
                miscompares++;
                $display("FAIL starve_grant%0d got addr=%h want %h", i, mem_addr, exp_if[i] ? 32'h200 : 32'h100);
            end
            mem_ack = 1'b1; mem_rdata = 32'h300 + i;
            tick();
            vectors++;
            if (if_done !== exp_if[i] || dm_done !== !exp_if[i]) begin
                miscompares++;
                $display("FAIL starve_done%0d got if=%b dm=%b want %b/%b", i, if_done, dm_done, exp_if[i], !exp_if[i]);
            end
            mem_ack = 1'b0;
            if (i == 5) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            tick();
            if (i != 5) tick();
        end
        vectors++; if (dm_rdata !== 32'h305) begin miscompares++; $display("FAIL starve_dm_rdata got %h want 305", dm_rdata); end
`ifdef MEM_ARB_STARVE_GUARD_EN
        vectors++; if (if_rdata !== 32'h304) begin miscompares++; $display("FAIL starve_if_rdata got %h want 304", if_rdata); end
`else
        vectors++; if (if_rdata !== 32'h0) begin miscompares++; $display("FAIL starve_if_rdata got %h want 0", if_rdata); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_data_write();
        test_reset_mid_access();
        test_stray_ack();
        test_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
